// File: rtl/er2_mailbox_pkg.sv
// Shared ER2 frame layout, FSM encoding and frame-length helper for ER2 endpoints.
// Frame bit positions are offsets above the DATA_W payload bits.
package er2_pkg;

  localparam int RD_ACK_BIT   = 0;
  localparam int WR_REQ_BIT   = 1;
  localparam int TX_FULL_BIT  = 0;
  localparam int RX_SPACE_BIT = 1;
  localparam int PARITY_BIT   = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CAPT   = 2'd1,
    SHIFT  = 2'd2,
    COMMIT = 2'd3
  } er2_state_t;

  function automatic int frame_len(input int data_w, input bit parity_en);
    return data_w + (parity_en ? PARITY_BIT + 1 : PARITY_BIT);
  endfunction

endpackage

// File: rtl/er2_sync_fifo.sv
// Synchronous FIFO with extra-bit wrapping pointers; a pop frees room for a push in the same cycle.
module er2_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head is forced to zero when empty so the output is clean out of reset.
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/er2_mailbox.sv
// IP-side ER2 data register: JTAG frames become RX FIFO pushes and TX holding-register acks.
// Build option ER2_MAILBOX_PARITY_EN adds an even-parity frame bit and a sticky parity_err output.
module er2_mailbox
  import er2_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int RX_DEPTH = 4
) (
  input  logic              JTCK,
  input  logic              JRSTN,
  input  logic              JTDI,
  input  logic              JSHIFT,
  input  logic              JUPDATE,
  input  logic              JCE2,
  input  logic              IP_ENABLE,
  output logic              ER2_TDO,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              rx_overflow,
`ifdef ER2_MAILBOX_PARITY_EN
  output logic              parity_err,
`endif
  output er2_state_t        state_dbg
);

`ifdef ER2_MAILBOX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int L     = frame_len(DATA_W, PAR_EN);
  localparam int CNT_W = $clog2(L + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(L);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(L + 1);

  er2_state_t        state, state_nxt;
  logic [L-1:0]      sr;
  logic [CNT_W-1:0]  bit_cnt;
  logic              capture, shift_en, upd;
  logic              load_sr, shift_sr, commit;
  logic              frame_ok;
  logic              wr_req, rd_ack;
  logic [DATA_W-1:0] tx_hold;
  logic              tx_full;
  logic              rx_full, rx_empty, rx_push;
  logic [DATA_W+1:0] cap_base;
  logic [L-1:0]      cap_word;

  assign capture  = JCE2 && IP_ENABLE && !JSHIFT;
  assign shift_en = JCE2 && IP_ENABLE && JSHIFT;
  assign upd      = JUPDATE && IP_ENABLE;

  assign cap_base = {!rx_full, tx_full, tx_hold};
`ifdef ER2_MAILBOX_PARITY_EN
  assign cap_word = {^cap_base, cap_base};
`else
  assign cap_word = cap_base;
`endif

  always_ff @(posedge JTCK) begin
    if (!JRSTN) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_sr   = 1'b0;
    shift_sr  = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (capture) begin
          load_sr   = 1'b1;
          state_nxt = CAPT;
        end
      end
      CAPT: begin
        if (capture) begin
          load_sr = 1'b1;
        end else if (shift_en) begin
          shift_sr  = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (upd) begin
          state_nxt = COMMIT;
        end else if (capture) begin
          load_sr   = 1'b1;
          state_nxt = CAPT;
        end else if (shift_en) begin
          shift_sr = 1'b1;
        end
      end
      COMMIT: begin
        commit    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // bit_cnt saturates one past L so over-long frames never alias back to L.
  always_ff @(posedge JTCK) begin
    if (!JRSTN) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (load_sr) begin
      sr      <= cap_word;
      bit_cnt <= '0;
    end else if (shift_sr) begin
      sr <= {JTDI, sr[L-1:1]};
      if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
    end
  end

  assign wr_req = sr[DATA_W + WR_REQ_BIT];
  assign rd_ack = sr[DATA_W + RD_ACK_BIT];

`ifdef ER2_MAILBOX_PARITY_EN
  assign frame_ok = commit && (bit_cnt == CNT_FULL) && !(^sr);

  always_ff @(posedge JTCK) begin
    if (!JRSTN) parity_err <= 1'b0;
    else if (commit && (bit_cnt == CNT_FULL) && (^sr)) parity_err <= 1'b1;
  end
`else
  assign frame_ok = commit && (bit_cnt == CNT_FULL);
`endif

  assign rx_push = frame_ok && wr_req;

  er2_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (RX_DEPTH)
  ) u_rx_fifo (
    .clk       (JTCK),
    .rst_n     (JRSTN),
    .push      (rx_push),
    .push_data (sr[DATA_W-1:0]),
    .pop       (rx_ready),
    .pop_data  (rx_data),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  assign rx_valid = !rx_empty;

  always_ff @(posedge JTCK) begin
    if (!JRSTN) rx_overflow <= 1'b0;
    else if (rx_push && rx_full && !(rx_ready && rx_valid)) rx_overflow <= 1'b1;
  end

  // A load needs tx_full=0 while an ack only matters at tx_full=1, so the two never contend.
  always_ff @(posedge JTCK) begin
    if (!JRSTN) begin
      tx_hold <= '0;
      tx_full <= 1'b0;
    end else if (tx_valid && !tx_full) begin
      tx_hold <= tx_data;
      tx_full <= 1'b1;
    end else if (frame_ok && rd_ack) begin
      tx_full <= 1'b0;
    end
  end

  assign tx_ready  = !tx_full;
  assign ER2_TDO   = sr[0];
  assign state_dbg = state;

endmodule

// File: tb/tb_er2_mailbox.sv
// Directed self-checking bench for er2_mailbox (DATA_W=8, RX_DEPTH=4, frame length 10).
module tb_er2_mailbox;
  import er2_pkg::*;

  logic       JTCK = 1'b0;
  logic       JRSTN = 1'b0;
  logic       JTDI = 1'b0;
  logic       JSHIFT = 1'b0;
  logic       JUPDATE = 1'b0;
  logic       JCE2 = 1'b0;
  logic       IP_ENABLE = 1'b1;
  logic       ER2_TDO;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       rx_overflow;
`ifdef ER2_MAILBOX_PARITY_EN
  logic       parity_err;
`endif
  er2_state_t state_dbg;

  int tests = 0;
  int fails = 0;
  logic [9:0] dout;

  er2_mailbox #(.DATA_W(8), .RX_DEPTH(4)) dut (
    .JTCK        (JTCK),
    .JRSTN       (JRSTN),
    .JTDI        (JTDI),
    .JSHIFT      (JSHIFT),
    .JUPDATE     (JUPDATE),
    .JCE2        (JCE2),
    .IP_ENABLE   (IP_ENABLE),
    .ER2_TDO     (ER2_TDO),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_overflow (rx_overflow),
`ifdef ER2_MAILBOX_PARITY_EN
    .parity_err  (parity_err),
`endif
    .state_dbg   (state_dbg)
  );

  always #5 JTCK = ~JTCK;

  // Inputs change 1 time unit after the rising edge; outputs are checked there too.
  task automatic step();
    @(posedge JTCK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Capture, shift nbits of din LSB first while recording TDO, update, then the commit cycle.
  task automatic do_frame(input logic [15:0] din, input int nbits, input bit pop_at_commit,
                          output logic [9:0] bits_out);
    bits_out = '0;
    JCE2 = 1'b1; JSHIFT = 1'b0;
    step();
    JSHIFT = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      if (i < 10) bits_out[i] = ER2_TDO;
      JTDI = din[i];
      step();
    end
    JCE2 = 1'b0; JSHIFT = 1'b0; JTDI = 1'b0; JUPDATE = 1'b1;
    step();
    JUPDATE = 1'b0; rx_ready = pop_at_commit;
    step();
    rx_ready = 1'b0;
  endtask

  task automatic pop_one();
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    JRSTN = 1'b0;
    step(); step();
    JRSTN = 1'b1;
    check("rst_tdo", ER2_TDO, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_overflow", rx_overflow, 0);
    check("rst_state", state_dbg, IDLE);

    // Idle frame: payload 0, tx empty, rx space -> captured 10'h200
    do_frame(16'h0000, 10, 1'b0, dout);
    check("idle_frame_tdo", dout, 10'h200);
    check("idle_rx_valid", rx_valid, 0);
    check("idle_tx_ready", tx_ready, 1);

    // Write 0xA5 with wr_req
    JCE2 = 1'b1; JSHIFT = 1'b0;
    step();
    JSHIFT = 1'b1;
    for (int i = 0; i < 10; i++) begin
      JTDI = 1'((16'h02A5 >> i) & 1);
      step();
    end
    JCE2 = 1'b0; JSHIFT = 1'b0; JTDI = 1'b0; JUPDATE = 1'b1;
    step();
    JUPDATE = 1'b0;
    check("wr_a5_before_commit", rx_valid, 0);
    step();
    check("wr_a5_valid", rx_valid, 1);
    check("wr_a5_data", rx_data, 8'hA5);
    pop_one();
    check("wr_a5_popped", rx_valid, 0);

    // Core sends 0x3C, host reads it with rd_ack
    tx_data = 8'h3C; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    check("tx_loaded_ready", tx_ready, 0);
    do_frame(16'h0100, 10, 1'b0, dout);
    check("tx_read_frame", dout, 10'h33C);
    check("tx_acked_ready", tx_ready, 1);

    // Five writes into a 4-deep FIFO
    for (int k = 1; k <= 4; k++) do_frame(16'h0200 | 16'(k), 10, 1'b0, dout);
    check("fill4_space_seen", dout, 10'h23C);
    check("fill4_no_overflow", rx_overflow, 0);
    do_frame(16'h0205, 10, 1'b0, dout);
    check("full_status_frame", dout, 10'h03C);
    check("overflow_set", rx_overflow, 1);
    for (int k = 1; k <= 4; k++) begin
      check("drain_order", rx_data, 32'(k));
      pop_one();
    end
    check("drain_empty", rx_valid, 0);
    check("overflow_sticky", rx_overflow, 1);

    // Short and long frames are discarded
    do_frame(16'h03FF, 9, 1'b0, dout);
    check("short_no_push", rx_valid, 0);
    do_frame(16'h07FF, 11, 1'b0, dout);
    check("long_no_push", rx_valid, 0);
    check("long_overflow_same", rx_overflow, 1);
    check("long_state_idle", state_dbg, IDLE);

    // Deselect mid-frame: captured 10'h23C, after 3 shifts TDO shows bit 3 = 1
    JCE2 = 1'b1; JSHIFT = 1'b0;
    step();
    JSHIFT = 1'b1; JTDI = 1'b1;
    step(); step(); step();
    IP_ENABLE = 1'b0;
    for (int i = 0; i < 4; i++) begin
      JTDI = 1'(i);
      step();
      check("deselect_tdo_static", ER2_TDO, 1);
    end
    JCE2 = 1'b0; JSHIFT = 1'b0; JUPDATE = 1'b1;
    step();
    JUPDATE = 1'b0;
    step();
    check("deselect_state_hold", state_dbg, SHIFT);
    check("deselect_no_commit", rx_valid, 0);
    IP_ENABLE = 1'b1;

    // Reset mid-SHIFT with two words queued
    do_frame(16'h0211, 10, 1'b0, dout);
    do_frame(16'h0222, 10, 1'b0, dout);
    check("pre_reset_valid", rx_valid, 1);
    JCE2 = 1'b1; JSHIFT = 1'b0;
    step();
    JSHIFT = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("pre_reset_state", state_dbg, SHIFT);
    JRSTN = 1'b0;
    step();
    check("mid_rst_rx_valid", rx_valid, 0);
    check("mid_rst_tx_ready", tx_ready, 1);
    check("mid_rst_state", state_dbg, IDLE);
    check("mid_rst_tdo", ER2_TDO, 0);
    check("mid_rst_overflow", rx_overflow, 0);
    JRSTN = 1'b1; JCE2 = 1'b0; JSHIFT = 1'b0;
    step();
    do_frame(16'h0277, 10, 1'b0, dout);
    check("post_rst_status", dout[9:8], 2'b10);
    check("post_rst_valid", rx_valid, 1);
    check("post_rst_data", rx_data, 8'h77);

    // Write to a full FIFO while the core pops in the commit cycle
    do_frame(16'h0288, 10, 1'b0, dout);
    do_frame(16'h0299, 10, 1'b0, dout);
    do_frame(16'h02AA, 10, 1'b0, dout);
    do_frame(16'h02BB, 10, 1'b1, dout);
    check("pushpop_full_seen", dout[9], 0);
    check("pushpop_no_overflow", rx_overflow, 0);
    check("pushpop_head", rx_data, 8'h88);
    pop_one();
    check("pushpop_d2", rx_data, 8'h99);
    pop_one();
    check("pushpop_d3", rx_data, 8'hAA);
    pop_one();
    check("pushpop_d4", rx_data, 8'hBB);
    pop_one();
    check("pushpop_empty", rx_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/er2_mailbox.md
Name: er2_mailbox

Overview:
- IP-side ER2 data register: the far end of the ER1 selector.
- It is selected by one IP_ENABLE bit from ER1 and shifts JTAG data in from JTDI and out on ER2_TDO.
- On update it turns each frame into word transfers: a JTAG-to-core receive FIFO and a core-to-JTAG transmit holding register.
- Every instance in lm32 debug and other IPs sits behind one ER1 IP_ENABLE/ER2_TDO slot.

Parameters:
- DATA_W, 8, payload bits per frame.
- RX_DEPTH, 4, receive FIFO entries; power of two, at least 2.

Ports:
- JTCK input 1: the single clock.
- JRSTN input 1: reset, synchronous, active-low.
- JTDI input 1: JTAG serial data in.
- JSHIFT input 1: shift-DR phase.
- JUPDATE input 1: update-DR strobe, one cycle.
- JCE2 input 1: ER2 instruction active (clock enable).
- IP_ENABLE input 1: this IP's bit from ER1.
- ER2_TDO output 1: serial data out, equal to shift-register bit 0.
- rx_data output DATA_W: FIFO head word.
- rx_valid output 1: FIFO not empty.
- rx_ready input 1: core consumes the head word.
- tx_data input DATA_W: core word for the host.
- tx_valid input 1: core offers tx_data.
- tx_ready output 1: holding register empty.
- rx_overflow output 1: sticky, a write was lost because the FIFO was full.

Behaviour:
- Frame length L = DATA_W+2, shifted LSB first.
  - Shifted-in bits: [DATA_W-1:0] payload, [DATA_W] rd_ack, [DATA_W+1] wr_req.
  - Captured bits: [DATA_W-1:0] tx_hold, [DATA_W] tx_full, [DATA_W+1] rx_space (FIFO not full).
- Qualifiers:
  - sel = JCE2 & IP_ENABLE.
  - capture = sel & !JSHIFT.
  - shift = sel & JSHIFT.
  - upd = JUPDATE & IP_ENABLE.
- FSM states:
  - IDLE: on capture, load the shift register, clear bit_cnt, go to CAPT.
  - CAPT: on shift go to SHIFT; a repeated capture reloads the register.
  - SHIFT: on each shift, sr <= {JTDI, sr[L-1:1]}; bit_cnt increments and saturates at L+1. On upd go to COMMIT. If capture arrives before upd, reload and return to CAPT.
  - COMMIT (one cycle): apply the frame only if bit_cnt == L, then go to IDLE. A short or long frame is discarded with no side effects.
- upd arriving from IDLE or CAPT is ignored (zero bits shifted).
- Commit actions:
  - wr_req=1: push the payload if the FIFO is not full, or if it is full and rx_ready & rx_valid in the same cycle. Otherwise set rx_overflow.
  - rd_ack=1 with tx_full: clear tx_full.
  - rd_ack=1 with tx_full=0: no effect.
- TX path:
  - tx_ready = !tx_full.
  - tx_valid & tx_ready loads tx_hold and sets tx_full.
  - A load and an rd_ack clear in the same cycle cannot collide, because the load requires tx_full=0.
- RX FIFO:
  - Pointers have log2(RX_DEPTH)+1 bits and wrap naturally.
  - rx_data is combinational from the head entry.
  - A pop on rx_valid & rx_ready takes effect in the same cycle as any push; simultaneous push and pop keeps the count unchanged.
- rx_overflow is cleared only by reset.
- Reset (JRSTN=0 at a JTCK edge), taking effect mid-frame or mid-commit:
  - FSM goes to IDLE; sr, bit_cnt, pointers, tx_full and rx_overflow all clear.
  - Outputs: ER2_TDO=0, rx_valid=0, rx_data=0, tx_ready=1, rx_overflow=0.
- Deselect: if IP_ENABLE drops mid-frame, the FSM holds. Only a subsequent capture restarts it.

Optional Feature:
- Macro ER2_MAILBOX_PARITY_EN.
- Defined:
  - L = DATA_W+3; bit [L-1] is even parity over all other shifted-in bits.
  - Captured bit [L-1] is the parity of the captured word.
  - A commit with a parity mismatch is discarded and sets a sticky output parity_err, reset 0.
- Undefined: L = DATA_W+2, no parity_err port, all frames with the correct length commit.

Decomposition:
- Package er2_pkg:
  - Frame bit-index localparams WR_REQ_BIT, RD_ACK_BIT, STATUS bit positions.
  - FSM state encodings IDLE, CAPT, SHIFT, COMMIT.
  - A function giving frame length from DATA_W and the parity option.
- One sub-module: er2_sync_fifo (parameterized DATA_W, DEPTH, push/pop/full/empty). It is reusable by other ER2 endpoints.

Test Plan:
- Reset, then capture and shift 10 bits with JTDI=0 (DATA_W=8) -> ER2_TDO sequence 0×8, 0, 1 (empty tx, rx space); rx_valid=0, tx_ready=1.
- Frame payload 0xA5 with wr_req=1, 10 bits, upd -> two cycles later rx_valid=1, rx_data=0xA5; pulse rx_ready -> rx_valid=0.
- Core sends tx_data=0x3C; frame with capture/shift/rd_ack=1 -> shifted-out payload 0x3C and tx_full bit 1; after commit tx_ready=1.
- Five wr_req frames 0x01..0x05 with rx_ready=0 -> first four stored in order, rx_overflow=1; drain reads 0x01..0x04.
- 9-bit and 11-bit frames with wr_req=1 -> no push, rx_overflow unchanged; IP_ENABLE=0 during shift -> ER2_TDO static, no commit.
- JRSTN low during SHIFT with the FIFO holding 2 words -> next cycle rx_valid=0, tx_ready=1, FSM IDLE; the next full frame commits normally.
